ex_stage: RTL
=============

# ex_stage

Execute stage of the 19-bit pipeline. Sits directly downstream of instruction decode and consumes its decoded opcode, two register operands and destination index. Single-cycle ALU operations return a registered result one cycle after acceptance. MUL/DIV/MOD run on an iterative shift-add / restoring-divide state machine that stalls upstream until the result is ready.

## Interface
No parameters; data width fixed at 19 bits, register index at 3 bits.
- clk  input  1  pipeline clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  decode has an instruction on the inputs this cycle
- opcode_in  input  5  decoded opcode (instruction bits 18:14)
- reg_data1_in  input  19  operand A (rs1 value)
- reg_data2_in  input  19  operand B (rs2 value)
- rd_in  input  3  destination register index
- stall  output  1  high while iterative op is in progress; upstream holds inputs
- valid_out  output  1  one-cycle pulse per completed instruction
- result_out  output  19  registered result
- rd_out  output  3  destination index of the completed instruction
- reg_write_out  output  1  result is to be written back (qualifies valid_out)
- zero_flag  output  1  last written result == 0
- carry_flag  output  1  carry (ADD) / borrow (SUB) of last ADD/SUB
- div_by_zero  output  1  one-cycle pulse with valid_out on DIV/MOD by zero
- illegal_op  output  1  one-cycle pulse with valid_out on an undefined opcode

## Operation
- Opcodes: 00000 NOP, 00001 ADD, 00010 SUB (A−B), 00011 AND, 00100 OR, 00101 XOR, 00110 NOT A, 00111 SHL, 01000 SHR (logical), 01001 INC A, 01010 DEC A, 01011 MUL, 01100 DIV, 01101 MOD; 01110–11111 undefined.
- All arithmetic is unsigned and modulo 2^19. MUL returns the low 19 bits of the product. DIV returns the quotient; MOD returns the remainder.
- Shift amount is reg_data2_in[4:0]. An amount ≥ 19 gives 0.
- reg_write_out is 1 for every defined op except NOP. Undefined ops give result 0, reg_write_out 0 and illegal_op 1.
- Divide by zero (B == 0) completes in a single cycle. DIV gives 19'h7FFFF; MOD gives A. div_by_zero pulses and reg_write_out is 1.
- zero_flag updates on every valid_out with reg_write_out = 1. carry_flag updates only on ADD/SUB. Both flags hold otherwise.
- FSM states:
  - IDLE: accepts when in_valid. Single-cycle ops and divide-by-zero stay in IDLE. MUL/DIV/MOD with a nonzero divisor latch A, B, rd and op, clear iteration counter to 0, then go to BUSY.
  - BUSY: performs one iteration per cycle. On the edge where the counter equals 18, writes the result, pulses valid_out and returns to IDLE.
- in_valid is ignored while in BUSY. Upstream is required to hold its instruction while stall = 1 and to present it again afterwards.

## Timing
- Reset values: stall 0, valid_out 0, result_out 0, rd_out 0, reg_write_out 0, zero_flag 0, carry_flag 0, div_by_zero 0, illegal_op 0. The FSM is in IDLE and the counter is 0.
- Single-cycle op latency: accepted at edge T0; outputs valid after T0 for exactly one cycle. Back-to-back acceptance runs every cycle.
- Iterative op latency:
  - Accepted at T0. stall goes high after T0 and is driven from the state register (no combinational path from inputs).
  - Result, rd_out and valid_out appear after T19. stall is low in that same cycle. A new instruction can be accepted at T20.
- Mid-operation reset aborts the iteration with no valid_out. Outputs return to reset values asynchronously.
- Between results, valid_out, div_by_zero and illegal_op are 0, and result_out and rd_out hold their last values.

## Configuration
- EX_MULDIV_EN defined: MUL/DIV/MOD are implemented as above, including the BUSY state and stall.
- EX_MULDIV_EN undefined:
  - The iterative datapath and BUSY state are not synthesised.
  - Opcodes 01011–01101 are treated as undefined: single cycle, result 0, reg_write_out 0, illegal_op 1.
  - stall is tied to 0.

## Test plan
- Reset, then ADD A=19'h7FFFF, B=1, rd=3: after one edge, result 0, zero_flag 1, carry_flag 1, rd_out 3, valid_out for 1 cycle.
- Back-to-back SUB 5−7 then SHL A=1, B=18 then SHR B=19: results 19'h7FFFE with carry_flag 1, then 19'h40000, then 0, on consecutive cycles.
- MUL 300×500 (EX_MULDIV_EN defined): stall is high for 19 cycles, then result 150000 with valid_out. in_valid toggled during the busy window is ignored.
- DIV 1000/7 and MOD 1000/7: 142 and 6, each after 19 stall cycles. DIV 5/0 gives 19'h7FFFF with div_by_zero pulse in one cycle and no stall.
- Opcode 11111: result 0, reg_write_out 0, illegal_op pulse, flags unchanged. With EX_MULDIV_EN undefined, MUL gives the same response with stall never asserted.
- Reset asserted 10 cycles into DIV: stall drops immediately and no valid_out occurs. An ADD issued after reset release completes normally.

Source files
------------

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - 19-bit execute stage: single-cycle ALU plus iterative MUL/DIV/MOD
// Optional iterative unit enabled by defining EX_MULDIV_EN.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [4:0]  opcode_in,
    input  logic [18:0] reg_data1_in,
    input  logic [18:0] reg_data2_in,
    input  logic [2:0]  rd_in,
    output logic        stall,
    output logic        valid_out,
    output logic [18:0] result_out,
    output logic [2:0]  rd_out,
    output logic        reg_write_out,
    output logic        zero_flag,
    output logic        carry_flag,
    output logic        div_by_zero,
    output logic        illegal_op
);

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_NOT = 5'd6;
    localparam logic [4:0] OP_SHL = 5'd7;
    localparam logic [4:0] OP_SHR = 5'd8;
    localparam logic [4:0] OP_INC = 5'd9;
    localparam logic [4:0] OP_DEC = 5'd10;
`ifdef EX_MULDIV_EN
    localparam logic [4:0] OP_MUL = 5'd11;
    localparam logic [4:0] OP_DIV = 5'd12;
    localparam logic [4:0] OP_MOD = 5'd13;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [4:0] LAST_ITER = 5'd18;
`endif

    logic        valid_q, valid_d;
    logic [18:0] result_q, result_d;
    logic [2:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        zero_q, zero_d;
    logic        carry_q, carry_d;
    logic        dbz_q, dbz_d;
    logic        ill_q, ill_d;

    logic        accept;
    logic [19:0] sum;
    logic [19:0] diff;
    logic [4:0]  shamt;

`ifdef EX_MULDIV_EN
    logic [0:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [18:0] a_q, a_d;
    logic [18:0] b_q, b_d;
    logic [18:0] acc_q, acc_d;
    logic [4:0]  mop_q, mop_d;
    logic [2:0]  mrd_q, mrd_d;
    logic [18:0] mul_acc_next;
    logic [19:0] div_shift;
    logic        div_ge;
    logic [19:0] div_rem_next;
    logic [18:0] div_quo_next;
`endif

    always_comb begin
        valid_d  = 1'b0;
        result_d = result_q;
        rd_d     = rd_q;
        rw_d     = 1'b0;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dbz_d    = 1'b0;
        ill_d    = 1'b0;
        sum      = {1'b0, reg_data1_in} + {1'b0, reg_data2_in};
        diff     = {1'b0, reg_data1_in} - {1'b0, reg_data2_in};
        shamt    = reg_data2_in[4:0];
`ifdef EX_MULDIV_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mop_d    = mop_q;
        mrd_d    = mrd_q;
        // One shift-add step for MUL, one restoring-divide step for DIV/MOD;
        // the divide keeps the dividend/quotient in a_q and the remainder in acc_q.
        mul_acc_next = acc_q + (b_q[0] ? a_q : 19'd0);
        div_shift    = {acc_q, a_q[18]};
        div_ge       = div_shift >= {1'b0, b_q};
        div_rem_next = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
        div_quo_next = {a_q[17:0], div_ge};
        accept       = in_valid && (state_q == ST_IDLE);
`else
        accept       = in_valid;
`endif

        if (accept) begin
            valid_d = 1'b1;
            rd_d    = rd_in;
            rw_d    = 1'b1;
            case (opcode_in)
                OP_NOP: rw_d = 1'b0;
                OP_ADD: begin
                    result_d = sum[18:0];
                    carry_d  = sum[19];
                end
                OP_SUB: begin
                    result_d = diff[18:0];
                    carry_d  = diff[19];
                end
                OP_AND: result_d = reg_data1_in & reg_data2_in;
                OP_OR:  result_d = reg_data1_in | reg_data2_in;
                OP_XOR: result_d = reg_data1_in ^ reg_data2_in;
                OP_NOT: result_d = ~reg_data1_in;
                OP_SHL: result_d = (shamt >= 5'd19) ? 19'd0 : (reg_data1_in << shamt);
                OP_SHR: result_d = (shamt >= 5'd19) ? 19'd0 : (reg_data1_in >> shamt);
                OP_INC: result_d = reg_data1_in + 19'd1;
                OP_DEC: result_d = reg_data1_in - 19'd1;
`ifdef EX_MULDIV_EN
                OP_MUL, OP_DIV, OP_MOD: begin
                    if (opcode_in != OP_MUL && reg_data2_in == 19'd0) begin
                        dbz_d    = 1'b1;
                        result_d = (opcode_in == OP_DIV) ? 19'h7FFFF : reg_data1_in;
                    end else begin
                        valid_d = 1'b0;
                        rw_d    = 1'b0;
                        rd_d    = rd_q;
                        state_d = ST_BUSY;
                        cnt_d   = 5'd0;
                        a_d     = reg_data1_in;
                        b_d     = reg_data2_in;
                        acc_d   = 19'd0;
                        mop_d   = opcode_in;
                        mrd_d   = rd_in;
                    end
                end
`endif
                default: begin
                    rw_d     = 1'b0;
                    ill_d    = 1'b1;
                    result_d = 19'd0;
                end
            endcase
        end
`ifdef EX_MULDIV_EN
        else if (state_q == ST_BUSY) begin
            cnt_d = cnt_q + 5'd1;
            if (mop_q == OP_MUL) begin
                acc_d = mul_acc_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
            end else begin
                acc_d = div_rem_next[18:0];
                a_d   = div_quo_next;
            end
            if (cnt_q == LAST_ITER) begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
                valid_d = 1'b1;
                rw_d    = 1'b1;
                rd_d    = mrd_q;
                if (mop_q == OP_MUL)
                    result_d = mul_acc_next;
                else if (mop_q == OP_DIV)
                    result_d = div_quo_next;
                else
                    result_d = div_rem_next[18:0];
            end
        end
`endif

        if (valid_d && rw_d)
            zero_d = (result_d == 19'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= 19'd0;
            rd_q     <= 3'd0;
            rw_q     <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
        end
    end

`ifdef EX_MULDIV_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            a_q     <= 19'd0;
            b_q     <= 19'd0;
            acc_q   <= 19'd0;
            mop_q   <= 5'd0;
            mrd_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mop_q   <= mop_d;
            mrd_q   <= mrd_d;
        end
    end

    assign stall = (state_q == ST_BUSY);
`else
    assign stall = 1'b0;
`endif

    assign valid_out     = valid_q;
    assign result_out    = result_q;
    assign rd_out        = rd_q;
    assign reg_write_out = rw_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign div_by_zero   = dbz_q;
    assign illegal_op    = ill_q;

endmodule
